// File: rtl/mux8_serializer_pkg.sv
// Shared definitions for the byte-to-bit serializer: state encoding,
// frame geometry and the select-ordering helper.
package mux8_serializer_pkg;

    localparam int FRAME_BITS = 8;
    localparam int SEL_W      = 3;

    localparam logic [SEL_W-1:0] CNT_FIRST = 3'd0;
    localparam logic [SEL_W-1:0] CNT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Map the in-frame bit counter onto the mux select for the chosen bit order.
    function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] cnt,
                                                 input logic             msb_first);
        logic [SEL_W-1:0] sel;
        if (msb_first) begin
            sel = CNT_LAST - cnt;
        end else begin
            sel = cnt;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux8_serializer_mux8.sv
// The 8:1 data mux: picks one bit of the held word according to the select.
module mux8_serializer_mux8
    import mux8_serializer_pkg::*;
(
    input  logic [FRAME_BITS-1:0] I,
    input  logic [SEL_W-1:0]      S,
    output logic                  O
);

    // Pure combinational bit selection.
    always_comb begin
        O = 1'b0;
        case (S)
            3'd0:    O = I[0];
            3'd1:    O = I[1];
            3'd2:    O = I[2];
            3'd3:    O = I[3];
            3'd4:    O = I[4];
            3'd5:    O = I[5];
            3'd6:    O = I[6];
            3'd7:    O = I[7];
            default: O = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux8_serializer.sv
// Byte-to-bit serializer: accepts a word over valid/ready, holds it on the
// mux inputs and walks the select through all eight positions, one bit per
// consumer transfer, with optional idle gap between frames.
module mux8_serializer
    import mux8_serializer_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned GAP       = 0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [SEL_W-1:0]      S,
    output logic                  sout,
    output logic                  sout_valid,
    input  logic                  sout_ready,
    output logic                  first,
    output logic                  last,
    output logic                  busy
);

    // A zero gap means the terminal transfer may chain straight into the next word.
    localparam bit         HAS_GAP    = (GAP != 0);
    localparam logic [3:0] GAP_RELOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    state_e                state_r;
    state_e                state_s;
    logic [FRAME_BITS-1:0] hold_r;
    logic [FRAME_BITS-1:0] hold_s;
    logic [SEL_W-1:0]      cnt_r;
    logic [SEL_W-1:0]      cnt_s;
    logic [3:0]            gap_cnt_r;
    logic [3:0]            gap_cnt_s;
    logic [SEL_W-1:0]      sel_s;
    logic                  ready_raw_s;
    logic                  xfer_s;

    // Handshake and frame-marker outputs decoded from the registered state.
    always_comb begin
        sel_s       = 3'd0;
        sout_valid  = 1'b0;
        first       = 1'b0;
        last        = 1'b0;
        busy        = 1'b0;
        ready_raw_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_raw_s = 1'b1;
            end
            ST_SHIFT: begin
                sout_valid  = 1'b1;
                busy        = 1'b1;
                sel_s       = sel_of(cnt_r, MSB_FIRST);
                first       = (cnt_r == CNT_FIRST);
                last        = (cnt_r == CNT_LAST);
                ready_raw_s = (!HAS_GAP) && (cnt_r == CNT_LAST) && sout_ready;
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                sel_s = 3'd0;
            end
        endcase
        if (rst) begin
            din_ready = 1'b0;
        end else begin
            din_ready = ready_raw_s;
        end
    end

    assign S      = sel_s;
    assign xfer_s = sout_valid & sout_ready;

    mux8_serializer_mux8 u_mux (
        .I (hold_r),
        .S (sel_s),
        .O (sout)
    );

    // Next-state, counter and word-capture decisions.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        cnt_s     = cnt_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (din_valid) begin
                    hold_s  = din;
                    cnt_s   = CNT_FIRST;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!xfer_s) begin
                    state_s = ST_SHIFT;
                end else if (cnt_r != CNT_LAST) begin
                    cnt_s = cnt_r + 3'd1;
                end else if (HAS_GAP) begin
                    cnt_s     = CNT_FIRST;
                    gap_cnt_s = GAP_RELOAD;
                    state_s   = ST_GAP;
                end else if (din_valid) begin
                    hold_s = din;
                    cnt_s  = CNT_FIRST;
                end else begin
                    cnt_s   = CNT_FIRST;
                    state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            hold_r    <= 8'd0;
            cnt_r     <= 3'd0;
            gap_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            cnt_r     <= cnt_s;
            gap_cnt_r <= gap_cnt_s;
        end
    end

endmodule
